// File: rtl/uart_io_bridge.sv
// uart_io_bridge: byte FIFOs between the processor I/O streams and the uart.
// TX bytes are held on uart_data_tx for a whole frame; RX bytes queue until read.
module uart_io_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            out_data,
    input  logic                  out_valid,
    output logic                  out_ready,
    output logic [7:0]            in_data,
    output logic                  in_valid,
    input  logic                  in_ready,
    input  logic [7:0]            uart_data_rx,
    input  logic                  uart_receive_done,
    output logic [7:0]            uart_data_tx,
    output logic                  uart_start_transmit,
    input  logic                  uart_tx_ready,
    output logic                  rx_overflow,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic [DEPTH_LOG2:0]   tx_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    localparam lvl_t FULL_LEVEL = lvl_t'(DEPTH);
    localparam lvl_t LVL_ONE    = lvl_t'(1);
    localparam ptr_t PTR_ONE    = ptr_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    ptr_t rx_head, rx_tail;
    ptr_t tx_head, tx_tail;
    logic rx_done_q;
    logic rx_full, rx_empty, rx_rise, rx_push, rx_pop;
    logic tx_full, tx_empty, tx_push, tx_pop;

    tx_state_t  state, state_next;
    logic [7:0] data_tx_next;
    logic       start_next;

    // RX side: edge-detected receive_done, drop only when full with no pop
    assign rx_full  = (rx_level == FULL_LEVEL);
    assign rx_empty = (rx_level == '0);
    assign rx_rise  = uart_receive_done & ~rx_done_q;
    assign in_valid = reset & ~rx_empty;
    assign rx_pop   = in_valid & in_ready;
    assign rx_push  = rx_rise & (~rx_full | rx_pop);
    assign in_data  = rx_empty ? 8'h00 : rx_mem[rx_head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_head     <= '0;
            rx_tail     <= '0;
            rx_level    <= '0;
            rx_done_q   <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_done_q <= uart_receive_done;
            if (rx_push) rx_tail <= rx_tail + PTR_ONE;
            if (rx_pop)  rx_head <= rx_head + PTR_ONE;
            if (rx_rise && rx_full && !rx_pop) rx_overflow <= 1'b1;
            if (rx_push && !rx_pop)
                rx_level <= rx_level + LVL_ONE;
            else if (rx_pop && !rx_push)
                rx_level <= rx_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_tail] <= uart_data_rx;
    end

    // TX side: out_ready comes from the registered level only
    assign tx_full   = (tx_level == FULL_LEVEL);
    assign tx_empty  = (tx_level == '0);
    assign out_ready = reset & ~tx_full;
    assign tx_push   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_head  <= '0;
            tx_tail  <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_tail <= tx_tail + PTR_ONE;
            if (tx_pop)  tx_head <= tx_head + PTR_ONE;
            if (tx_push && !tx_pop)
                tx_level <= tx_level + LVL_ONE;
            else if (tx_pop && !tx_push)
                tx_level <= tx_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_tail] <= out_data;
    end

    always_comb begin
        state_next   = state;
        tx_pop       = 1'b0;
        start_next   = 1'b0;
        data_tx_next = uart_data_tx;
        unique case (state)
            IDLE: begin
                if (!tx_empty && uart_tx_ready) begin
                    tx_pop       = 1'b1;
                    start_next   = 1'b1;
                    data_tx_next = tx_mem[tx_head];
                    state_next   = START;
                end
            end
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (!uart_tx_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (uart_tx_ready) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            uart_data_tx        <= 8'h00;
            uart_start_transmit <= 1'b0;
        end else begin
            state               <= state_next;
            uart_data_tx        <= data_tx_next;
            uart_start_transmit <= start_next;
        end
    end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Bench for uart_io_bridge: uart line model, RX queue model, TX frame decoder.
// Random bytes are checked against queue-based expectations.
module tb_uart_io_bridge;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    out_data = 8'h00;
    logic          out_valid = 1'b0;
    logic          out_ready;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready = 1'b0;
    logic [7:0]    uart_data_rx = 8'h00;
    logic          uart_receive_done = 1'b0;
    logic [7:0]    uart_data_tx;
    logic          uart_start_transmit;
    logic          uart_tx_ready;
    logic          rx_overflow;
    logic [DL:0]   rx_level;
    logic [DL:0]   tx_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_io_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk(clk),
        .reset(reset),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .uart_data_rx(uart_data_rx),
        .uart_receive_done(uart_receive_done),
        .uart_data_tx(uart_data_tx),
        .uart_start_transmit(uart_start_transmit),
        .uart_tx_ready(uart_tx_ready),
        .rx_overflow(rx_overflow),
        .rx_level(rx_level),
        .tx_level(tx_level)
    );

    // uart transmitter model: 10-bit frame, tx_ready low for the whole frame
    logic       tx_line;
    int         bit_idx;
    logic [9:0] frame;

    always @(posedge clk) begin
        if (!reset) begin
            uart_tx_ready <= 1'b1;
            tx_line       <= 1'b1;
            bit_idx       <= 0;
        end else if (uart_tx_ready) begin
            if (uart_start_transmit) begin
                frame         <= {1'b1, uart_data_tx, 1'b0};
                tx_line       <= 1'b0;
                bit_idx       <= 0;
                uart_tx_ready <= 1'b0;
            end
        end else if (bit_idx == 9) begin
            uart_tx_ready <= 1'b1;
            tx_line       <= 1'b1;
        end else begin
            bit_idx <= bit_idx + 1;
            tx_line <= frame[bit_idx+1];
        end
    end

    // line monitor: records start pulses and decodes serialized bytes
    logic [7:0] cap_start[$];
    int         cap_cyc[$];
    logic [7:0] cap_line[$];
    logic [9:0] shreg;
    int         nbits = 0;
    logic [7:0] held = 8'h00;
    logic       prev_start = 1'b0;
    int         hold_err = 0;
    int         pulse_err = 0;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (!reset) begin
            nbits      = 0;
            prev_start = 1'b0;
        end else begin
            if (uart_start_transmit) begin
                if (prev_start) pulse_err++;
                cap_start.push_back(uart_data_tx);
                cap_cyc.push_back(cyc);
                held = uart_data_tx;
            end
            prev_start = uart_start_transmit;
            if (!uart_tx_ready) begin
                if (uart_data_tx !== held) hold_err++;
                shreg[nbits] = tx_line;
                nbits++;
                if (nbits == 10) begin
                    if (shreg[0] !== 1'b0 || shreg[9] !== 1'b1) frame_err++;
                    cap_line.push_back(shreg[8:1]);
                    nbits = 0;
                end
            end
        end
    end

    // RX reference: a plain queue plus a sticky overflow flag
    logic [7:0] rxq[$];
    logic       rx_ovf = 1'b0;

    task automatic clear_caps();
        cap_start.delete();
        cap_cyc.delete();
        cap_line.delete();
        hold_err  = 0;
        pulse_err = 0;
        frame_err = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        out_valid = 1'b0;
        in_ready = 1'b0;
        uart_receive_done = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        rxq.delete();
        rx_ovf = 1'b0;
        @(negedge clk);
        clear_caps();
    endtask

    task automatic push_tx(input logic [7:0] b, output int acc);
        int t = 0;
        out_data = b;
        out_valid = 1'b1;
        while (!out_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        out_valid = 1'b0;
        acc = cyc;
        checks++;
        if (t >= 500) begin errors++; $display("FAIL push_tx_timeout got %0d cycles want <500", t); end
    endtask

    task automatic wait_lines(input int n);
        int t = 0;
        while (cap_line.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cap_line.size() < n) begin errors++; $display("FAIL wait_lines got %0d want %0d", cap_line.size(), n); end
    endtask

    task automatic rx_push(input logic [7:0] b);
        uart_data_rx = b;
        uart_receive_done = 1'b1;
        @(negedge clk);
        uart_receive_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_pop();
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic popped);
        if (popped && rxq.size() > 0) void'(rxq.pop_front());
        if (rxq.size() == DEPTH) rx_ovf = 1'b1;
        else rxq.push_back(b);
    endtask

    task automatic drain_rx(input string name);
        while (rxq.size() > 0) begin
            checks++;
            if (in_valid !== 1'b1 || in_data !== rxq[0]) begin
                errors++;
                $display("FAIL %s_drain got v=%b d=%h want v=1 d=%h", name, in_valid, in_data, rxq[0]);
            end
            void'(rxq.pop_front());
            rx_pop();
        end
        checks++;
        if (in_valid !== 1'b0 || rx_level !== 0 || in_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_empty got v=%b l=%0d d=%h want 0 0 00", name, in_valid, rx_level, in_data);
        end
    endtask

    task automatic check_tx(input string name, input logic [7:0] exp[$]);
        checks++;
        if (cap_start.size() !== exp.size()) begin errors++; $display("FAIL %s_pulses got %0d want %0d", name, cap_start.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < cap_start.size() && i < cap_line.size(); i++) begin
            checks++;
            if (cap_start[i] !== exp[i] || cap_line[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_byte%0d got tx=%h line=%h want %h", name, i, cap_start[i], cap_line[i], exp[i]);
            end
            if (i > 0) begin
                checks++;
                if (cap_cyc[i] - cap_cyc[i-1] !== 13) begin
                    errors++;
                    $display("FAIL %s_gap%0d got %0d want 13", name, i, cap_cyc[i] - cap_cyc[i-1]);
                end
            end
        end
        checks++;
        if (hold_err !== 0 || pulse_err !== 0 || frame_err !== 0) begin
            errors++;
            $display("FAIL %s_line got hold=%0d pulse=%0d frame=%0d want 0 0 0", name, hold_err, pulse_err, frame_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL rst_out_ready got %b want 0", out_ready); end
        checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got %b want 0", in_valid); end
        checks++; if (uart_start_transmit !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", uart_start_transmit); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", rx_overflow); end
        checks++; if (uart_data_tx !== 8'h00 || in_data !== 8'h00) begin errors++; $display("FAIL rst_data got tx=%h in=%h want 00", uart_data_tx, in_data); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL rel_out_ready got %b want 1", out_ready); end
        checks++; if (rx_level !== 0 || tx_level !== 0) begin errors++; $display("FAIL rel_levels got rx=%0d tx=%0d want 0", rx_level, tx_level); end
    endtask

    task automatic test_tx_fixed();
        logic [7:0] exp[$];
        int acc;
        int first;
        exp = '{8'h2B, 8'h2E, 8'h5B};
        clear_caps();
        push_tx(exp[0], first);
        push_tx(exp[1], acc);
        push_tx(exp[2], acc);
        wait_lines(3);
        repeat (4) @(negedge clk);
        check_tx("tx_fixed", exp);
        checks++;
        if (cap_cyc.size() < 1 || cap_cyc[0] !== first + 1) begin
            errors++;
            $display("FAIL tx_latency got %0d want %0d", cap_cyc.size() > 0 ? cap_cyc[0] : -1, first + 1);
        end
        checks++; if (tx_level !== 0) begin errors++; $display("FAIL tx_fixed_level got %0d want 0", tx_level); end
    endtask

    task automatic test_rx_basic();
        uart_data_rx = 8'h41;
        uart_receive_done = 1'b1;
        @(negedge clk);
        uart_receive_done = 1'b0;
        checks++; if (in_valid !== 1'b1 || in_data !== 8'h41) begin errors++; $display("FAIL rx_latency got v=%b d=%h want 1 41", in_valid, in_data); end
        @(negedge clk);
        rx_push(8'h42);
        checks++; if (rx_level !== 2 || in_data !== 8'h41) begin errors++; $display("FAIL rx_two got l=%0d d=%h want 2 41", rx_level, in_data); end
        rx_pop();
        checks++; if (rx_level !== 1 || in_data !== 8'h42) begin errors++; $display("FAIL rx_pop1 got l=%0d d=%h want 1 42", rx_level, in_data); end
        rx_pop();
        checks++; if (in_valid !== 1'b0 || in_data !== 8'h00) begin errors++; $display("FAIL rx_pop2 got v=%b d=%h want 0 00", in_valid, in_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        do_reset(2);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            rx_push(b);
            model_rx(b, 1'b0);
        end
        checks++; if (rx_level !== DEPTH) begin errors++; $display("FAIL ovf_level got %0d want %0d", rx_level, DEPTH); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", rx_overflow); end
        drain_rx("ovf");
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", rx_overflow); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            rx_push(b);
            model_rx(b, 1'b0);
        end
        b = 8'($urandom);
        uart_data_rx = b;
        uart_receive_done = 1'b1;
        in_ready = 1'b1;
        checks++; if (in_data !== rxq[0]) begin errors++; $display("FAIL fullpop_head got %h want %h", in_data, rxq[0]); end
        @(negedge clk);
        uart_receive_done = 1'b0;
        in_ready = 1'b0;
        model_rx(b, 1'b1);
        checks++; if (rx_level !== DEPTH) begin errors++; $display("FAIL fullpop_level got %0d want %0d", rx_level, DEPTH); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", rx_overflow); end
        drain_rx("fullpop");
        b = 8'($urandom);
        uart_data_rx = b;
        uart_receive_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            uart_data_rx = ~b;
        end
        uart_receive_done = 1'b0;
        @(negedge clk);
        rxq.push_back(b);
        checks++; if (rx_level !== 1) begin errors++; $display("FAIL hold_level got %0d want 1", rx_level); end
        drain_rx("hold");
    endtask

    task automatic test_random_rx();
        logic [7:0] b;
        logic       push, pop;
        do_reset(2);
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom);
            push = ($urandom_range(0, 2) != 0);
            pop = ($urandom_range(0, 1) != 0);
            if (rxq.size() > 0) begin
                checks++;
                if (in_valid !== 1'b1 || in_data !== rxq[0]) begin
                    errors++;
                    $display("FAIL rand_head%0d got v=%b d=%h want 1 %h", i, in_valid, in_data, rxq[0]);
                end
            end
            uart_data_rx = b;
            uart_receive_done = push;
            in_ready = pop;
            @(negedge clk);
            uart_receive_done = 1'b0;
            in_ready = 1'b0;
            if (push) model_rx(b, pop);
            else if (pop && rxq.size() > 0) void'(rxq.pop_front());
            @(negedge clk);
            checks++;
            if (rx_level !== rxq.size() || rx_overflow !== rx_ovf) begin
                errors++;
                $display("FAIL rand_state%0d got l=%0d o=%b want l=%0d o=%b", i, rx_level, rx_overflow, rxq.size(), rx_ovf);
            end
        end
        drain_rx("rand");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int acc;
        do_reset(2);
        for (int i = 0; i < 9; i++) exp.push_back(8'($urandom));
        foreach (exp[i]) push_tx(exp[i], acc);
        wait_lines(9);
        repeat (4) @(negedge clk);
        check_tx("b2b", exp);
        checks++; if (tx_level !== 0 || out_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got l=%0d r=%b want 0 1", tx_level, out_ready); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp[$];
        int acc;
        int first;
        do_reset(2);
        push_tx(8'h12, acc);
        for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom), acc);
        checks++; if (tx_level !== DEPTH) begin errors++; $display("FAIL mid_level got %0d want %0d", tx_level, DEPTH); end
        checks++;
        if (cap_start.size() !== 1 || cap_start[0] !== 8'h12) begin
            errors++;
            $display("FAIL mid_first got n=%0d want 1 byte 12", cap_start.size());
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tx_level !== 0 || uart_data_tx !== 8'h00) begin errors++; $display("FAIL mid_rst got l=%0d d=%h want 0 00", tx_level, uart_data_tx); end
        reset = 1'b1;
        clear_caps();
        repeat (40) @(negedge clk);
        checks++; if (cap_start.size() !== 0) begin errors++; $display("FAIL mid_quiet got %0d pulses want 0", cap_start.size()); end
        exp = '{8'h5A};
        push_tx(8'h5A, first);
        wait_lines(1);
        repeat (4) @(negedge clk);
        check_tx("mid_after", exp);
        checks++;
        if (cap_cyc.size() < 1 || cap_cyc[0] !== first + 1) begin
            errors++;
            $display("FAIL mid_idle_latency got %0d want %0d", cap_cyc.size() > 0 ? cap_cyc[0] : -1, first + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_fixed();
        test_rx_basic();
        test_overflow();
        test_full_pop();
        test_random_rx();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
